alu_cmd_sequencer: RTL and testbench

Command-side driver for the `alu` block: accepts accumulator-style ALU commands over a valid/ready handshake, drives the ALU operand/select/carry inputs from registers, waits a fixed settle time, then captures result and flags. Holds the accumulator and flag register and returns each result over a second valid/ready handshake. Sits between the datapath controller and a combinational `alu` instance with matching N.

---
 rtl/alu_cmd_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Accumulator-style command sequencer for a combinational ALU: accepts commands,
// holds the ALU inputs for SETTLE cycles, captures result/flags and returns them.
module alu_cmd_sequencer #(
  parameter int N      = 10,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [N-1:0] cmd_operand,
  input  logic         cmd_load,
  input  logic         cmd_use_carry,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_carry_in,
  output logic [2:0]   alu_select,
  input  logic [N-1:0] alu_result,
  input  logic         alu_n,
  input  logic         alu_c,
  input  logic         alu_v,
  input  logic         alu_z,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic [N-1:0] acc,
  output logic         busy
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // EXEC  | ALU inputs held, settle counter running down to capture
  // RESP  | response presented, waiting for rsp_ready

  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("alu_cmd_sequencer: SETTLE must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic [3:0] flags_q;
  logic       accept;
  logic       capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = cmd_load ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // ALU inputs move only on a non-load accept so the ALU sees stable operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_select   <= '0;
      alu_carry_in <= 1'b0;
      cnt_q        <= '0;
    end else if (accept && !cmd_load) begin
      alu_a        <= acc;
      alu_b        <= cmd_operand;
      alu_select   <= cmd_op;
      alu_carry_in <= cmd_use_carry & flags_q[2];
      cnt_q        <= SETTLE_M1;
    end else if (state_q == EXEC && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      flags_q    <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else if (accept && cmd_load) begin
      acc        <= cmd_operand;
      rsp_result <= cmd_operand;
      rsp_flags  <= flags_q;
    end else if (capture) begin
      acc        <= alu_result;
      flags_q    <= {alu_n, alu_c, alu_v, alu_z};
      rsp_result <= alu_result;
      rsp_flags  <= {alu_n, alu_c, alu_v, alu_z};
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: two instances (SETTLE=1 and SETTLE=3), each fed by
// a behavioural ALU, checked against an accumulator/flags reference model.
module tb_alu_cmd_sequencer;
  localparam int N = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         cmd_valid[2], cmd_ready[2], cmd_load[2], cmd_use_carry[2];
  logic [2:0]   cmd_op[2], alu_select[2];
  logic [N-1:0] cmd_operand[2], alu_a[2], alu_b[2], alu_result[2];
  logic [N-1:0] rsp_result[2], acc[2], perturb[2];
  logic         alu_carry_in[2], alu_n[2], alu_c[2], alu_v[2], alu_z[2];
  logic         rsp_valid[2], rsp_ready[2], busy[2];
  logic [3:0]   rsp_flags[2];
  logic [N+3:0] alu_out[2];

  logic [N-1:0] m_acc[2];
  logic [3:0]   m_flags[2];
  int tests = 0;
  int fails = 0;

  // Reference ALU: returns {n,c,v,z,result}; carry_in only affects add/sub
  function automatic logic [N+3:0] alu_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [2:0] sel, input logic cin);
    int ua, ub, sa, sb, full, sfull;
    logic [N-1:0] res;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = a[N-1] ? ua - (1 << N) : ua;
    sb = b[N-1] ? ub - (1 << N) : ub;
    c = 1'b0; v = 1'b0; full = 0; sfull = 0;
    case (sel)
      3'd0: begin full = ua + ub + int'(cin); sfull = sa + sb + int'(cin); c = (full >= (1 << N)); end
      3'd1: begin full = ua - ub - int'(cin); sfull = sa - sb - int'(cin); c = (full < 0); end
      3'd2: begin full = ua + 1; sfull = sa + 1; c = (full >= (1 << N)); end
      3'd3: begin full = ua - 1; sfull = sa - 1; c = (full < 0); end
      3'd4: full = int'(a & b);
      3'd5: full = int'(a | b);
      3'd6: full = int'(a ^ b);
      default: full = int'(~a);
    endcase
    res = full[N-1:0];
    if (sel <= 3'd3) v = (sfull > (1 << (N-1)) - 1) || (sfull < -(1 << (N-1)));
    return {res[N-1], c, v, (res == '0), res};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_alu
    assign alu_out[g]    = alu_ref(alu_a[g], alu_b[g], alu_select[g], alu_carry_in[g]);
    assign alu_result[g] = alu_out[g][N-1:0] ^ perturb[g];
    assign alu_n[g]      = alu_out[g][N+3];
    assign alu_c[g]      = alu_out[g][N+2];
    assign alu_v[g]      = alu_out[g][N+1];
    assign alu_z[g]      = alu_out[g][N];
  end

  alu_cmd_sequencer #(.N(N), .SETTLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_operand(cmd_operand[0]), .cmd_load(cmd_load[0]),
    .cmd_use_carry(cmd_use_carry[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
    .alu_carry_in(alu_carry_in[0]), .alu_select(alu_select[0]), .alu_result(alu_result[0]),
    .alu_n(alu_n[0]), .alu_c(alu_c[0]), .alu_v(alu_v[0]), .alu_z(alu_z[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
    .rsp_flags(rsp_flags[0]), .acc(acc[0]), .busy(busy[0]));

  alu_cmd_sequencer #(.N(N), .SETTLE(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_operand(cmd_operand[1]), .cmd_load(cmd_load[1]),
    .cmd_use_carry(cmd_use_carry[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
    .alu_carry_in(alu_carry_in[1]), .alu_select(alu_select[1]), .alu_result(alu_result[1]),
    .alu_n(alu_n[1]), .alu_c(alu_c[1]), .alu_v(alu_v[1]), .alu_z(alu_z[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
    .rsp_flags(rsp_flags[1]), .acc(acc[1]), .busy(busy[1]));

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [49:0] out_vec(input int d);
    return {acc[d], alu_a[d], alu_b[d], alu_select[d], alu_carry_in[d],
            rsp_result[d], rsp_flags[d], rsp_valid[d], busy[d]};
  endfunction

  // One full command transaction on instance d; called at posedge+1
  task automatic do_cmd(input int d, input logic ld, input logic [2:0] op,
                        input logic [N-1:0] opd, input logic uc, input int stall,
                        input logic perturb_en);
    logic [N+3:0] e;
    logic [N-1:0] exp_res;
    logic [3:0]   exp_fl;
    logic         cin;
    int           cyc;
    cyc = 0;
    while (!cmd_ready[d] && cyc < 20) begin @(posedge clk); #1; cyc++; end
    tests++;
    if (cmd_ready[d] !== 1'b1) begin
      fails++; $display("FAIL idle_ready[%0d]: got %b want 1", d, cmd_ready[d]);
    end
    cin = uc & m_flags[d][2];
    if (ld) begin
      exp_res = opd; exp_fl = m_flags[d];
    end else begin
      e = alu_ref(m_acc[d], opd, op, cin);
      exp_res = e[N-1:0]; exp_fl = e[N+3:N];
    end
    cmd_valid[d] = 1'b1; cmd_load[d] = ld; cmd_op[d] = op;
    cmd_operand[d] = opd; cmd_use_carry[d] = uc;
    @(posedge clk); #1;
    cmd_valid[d] = 1'b0;
    if (perturb_en && !ld) perturb[d] = 10'h2A5;
    cyc = 0;
    while (!rsp_valid[d] && cyc < 40) begin
      tests++;
      if ({alu_a[d], alu_b[d], alu_select[d], alu_carry_in[d]} !== {m_acc[d], opd, op, cin}) begin
        fails++;
        $display("FAIL alu_hold[%0d] cyc %0d: got a=%h b=%h sel=%0d cin=%b want a=%h b=%h sel=%0d cin=%b",
                 d, cyc, alu_a[d], alu_b[d], alu_select[d], alu_carry_in[d], m_acc[d], opd, op, cin);
      end
      if (cyc == settle_of(d) - 1) perturb[d] = '0;
      @(posedge clk); #1; cyc++;
    end
    perturb[d] = '0;
    tests++;
    if (cyc !== (ld ? 0 : settle_of(d))) begin
      fails++; $display("FAIL latency[%0d]: got %0d want %0d", d, cyc, ld ? 0 : settle_of(d));
    end
    tests++;
    if ({rsp_result[d], rsp_flags[d], acc[d], busy[d], cmd_ready[d]} !== {exp_res, exp_fl, exp_res, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL response[%0d] op=%0d ld=%b: got res=%h flags=%b acc=%h busy=%b rdy=%b want res=%h flags=%b",
               d, op, ld, rsp_result[d], rsp_flags[d], acc[d], busy[d], cmd_ready[d], exp_res, exp_fl);
    end
    m_acc[d] = exp_res;
    if (!ld) m_flags[d] = exp_fl;
    for (int i = 0; i < stall; i++) begin
      cmd_valid[d] = 1'b1; cmd_load[d] = 1'b1; cmd_operand[d] = N'($urandom);
      @(posedge clk); #1;
      tests++;
      if ({rsp_valid[d], rsp_result[d], rsp_flags[d], cmd_ready[d], acc[d]} !== {1'b1, exp_res, exp_fl, 1'b0, exp_res}) begin
        fails++;
        $display("FAIL stall[%0d] cyc %0d: got vld=%b res=%h flags=%b rdy=%b acc=%h want res=%h flags=%b",
                 d, i, rsp_valid[d], rsp_result[d], rsp_flags[d], cmd_ready[d], acc[d], exp_res, exp_fl);
      end
    end
    cmd_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    tests++;
    if ({rsp_valid[d], cmd_ready[d], busy[d]} !== 3'b010) begin
      fails++; $display("FAIL release[%0d]: got vld/rdy/busy=%b want 010", d, {rsp_valid[d], cmd_ready[d], busy[d]});
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin m_acc[d] = '0; m_flags[d] = '0; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    reset_model();
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 0; cmd_load[d] = 0; cmd_op[d] = 0; cmd_operand[d] = 0;
      cmd_use_carry[d] = 0; rsp_ready[d] = 0; perturb[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if ({out_vec(d), cmd_ready[d]} !== {50'd0, 1'b1}) begin
        fails++; $display("FAIL reset_state[%0d]: got %h rdy=%b want 0 rdy=1", d, out_vec(d), cmd_ready[d]);
      end
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_cmd(0, 1, 3'd0, 10'd6, 0, 0, 0);
    do_cmd(0, 0, 3'd0, 10'd5, 0, 0, 0);
    tests++;
    if ({rsp_result[0], acc[0], rsp_flags[0][3], rsp_flags[0][0]} !== {10'h00B, 10'h00B, 2'b00}) begin
      fails++; $display("FAIL add_6_5: got res=%h acc=%h flags=%b want 00b", rsp_result[0], acc[0], rsp_flags[0]);
    end
    do_cmd(0, 1, 3'd0, 10'd1, 0, 0, 0);
    do_cmd(0, 0, 3'd3, 10'd0, 0, 0, 0);
    tests++;
    if ({rsp_result[0], rsp_flags[0][3], rsp_flags[0][0]} !== {10'h000, 2'b01}) begin
      fails++; $display("FAIL dec_to_zero: got res=%h flags=%b want 000 N=0 Z=1", rsp_result[0], rsp_flags[0]);
    end
    do_cmd(0, 0, 3'd2, 10'd0, 0, 0, 0);
    tests++;
    if ({rsp_result[0], rsp_flags[0][0]} !== {10'h001, 1'b0}) begin
      fails++; $display("FAIL inc_to_one: got res=%h flags=%b want 001 Z=0", rsp_result[0], rsp_flags[0]);
    end
    do_cmd(0, 1, 3'd0, 10'd6, 0, 0, 0);
    do_cmd(0, 0, 3'd7, 10'h155, 0, 0, 0);
    tests++;
    if ({rsp_result[0], rsp_flags[0][3], rsp_flags[0][0]} !== {10'h3F9, 2'b10}) begin
      fails++; $display("FAIL not_6: got res=%h flags=%b want 3f9 N=1 Z=0", rsp_result[0], rsp_flags[0]);
    end
    do_cmd(0, 0, 3'd4, 10'h00F, 0, 0, 0);
    tests++;
    if (rsp_result[0] !== 10'h009) begin
      fails++; $display("FAIL and_0f: got %h want 009", rsp_result[0]);
    end
    do_cmd(0, 0, 3'd6, 10'h009, 0, 0, 0);
    tests++;
    if ({rsp_result[0], rsp_flags[0][0]} !== {10'h000, 1'b1}) begin
      fails++; $display("FAIL xor_self: got res=%h flags=%b want 000 Z=1", rsp_result[0], rsp_flags[0]);
    end
    // load after an ALU op must leave the flags untouched
    do_cmd(0, 1, 3'd0, 10'h3FF, 0, 0, 0);
    do_cmd(0, 0, 3'd0, 10'h001, 1, 0, 0);
    do_cmd(0, 0, 3'd0, 10'h001, 1, 0, 0);
  endtask

  task automatic test_settle3();
    do_cmd(1, 1, 3'd0, 10'h100, 0, 0, 0);
    do_cmd(1, 0, 3'd0, 10'h023, 0, 0, 1);
    do_cmd(1, 0, 3'd1, 10'h200, 1, 0, 1);
    do_cmd(1, 0, 3'd5, 10'h00F, 1, 0, 1);
  endtask

  task automatic test_backpressure();
    do_cmd(0, 0, 3'd0, 10'h07E, 0, 5, 0);
    do_cmd(0, 1, 3'd0, 10'h2C3, 0, 5, 0);
  endtask

  task automatic test_reset_mid_exec();
    do_cmd(1, 1, 3'd0, 10'h123, 0, 0, 0);
    cmd_valid[1] = 1'b1; cmd_load[1] = 1'b0; cmd_op[1] = 3'd0;
    cmd_operand[1] = 10'h011; cmd_use_carry[1] = 1'b0;
    @(posedge clk); #1;
    cmd_valid[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    tests++;
    if ({out_vec(1), cmd_ready[1]} !== {50'd0, 1'b1}) begin
      fails++; $display("FAIL mid_exec_reset: got %h rdy=%b want 0 rdy=1", out_vec(1), cmd_ready[1]);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++;
      if ({rsp_valid[1], busy[1]} !== 2'b00) begin
        fails++; $display("FAIL dropped_cmd cyc %0d: got vld/busy=%b want 00", i, {rsp_valid[1], busy[1]});
      end
    end
    do_cmd(1, 0, 3'd0, 10'h007, 0, 0, 0);
    tests++;
    if (acc[1] !== 10'h007) begin
      fails++; $display("FAIL after_reset_add: got %h want 007", acc[1]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int d;
      d = i % 2;
      do_cmd(d, ($urandom_range(0, 3) == 0), 3'($urandom), N'($urandom), 1'($urandom),
             $urandom_range(0, 3), (d == 1) && ($urandom_range(0, 1) == 1));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_settle3();
    test_backpressure();
    test_reset_mid_exec();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
